// File: rtl/accelerator_usage_vector_multihead_pkg.sv
// Shared DNC datapath definitions: FSM state encoding, fixed-point ONE and
// saturate-to-ONE helpers.
package accelerator_dnc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMBINE = 2'd2,
        ST_SCALE   = 2'd3
    } dnc_state_e;

    // Helpers work at a generous fixed width; callers narrow with explicit casts.
    localparam int unsigned MAX_W = 128;

    function automatic logic [MAX_W-1:0] fixed_one(input int unsigned frac);
        return MAX_W'(1) << frac;
    endfunction

    function automatic logic [MAX_W-1:0] sat_one(input logic [MAX_W-1:0] x,
                                                 input int unsigned frac);
        logic [MAX_W-1:0] one;
        one = fixed_one(frac);
        return (x > one) ? one : x;
    endfunction

endpackage

// File: rtl/accelerator_usage_vector_multihead_if.sv
// Operand/result stream bundle between the weighting producers and the usage block.
interface accelerator_usage_vector_multihead_if #(
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned HEAD_W    = 1
);
    logic                 START;
    logic                 READY;
    logic                 U_IN_ENABLE;
    logic                 W_IN_ENABLE;
    logic                 PSI_IN_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_N_IN;
    logic [DATA_SIZE-1:0] U_IN;
    logic [DATA_SIZE-1:0] W_IN;
    logic [DATA_SIZE-1:0] PSI_IN;
    logic [HEAD_W-1:0]    W_HEAD_OUT;
    logic [DATA_SIZE-1:0] U_OUT;
    logic                 U_OUT_ENABLE;

    modport master (
        output START, U_IN_ENABLE, W_IN_ENABLE, PSI_IN_ENABLE,
        output SIZE_N_IN, U_IN, W_IN, PSI_IN,
        input  READY, W_HEAD_OUT, U_OUT, U_OUT_ENABLE
    );

    modport slave (
        input  START, U_IN_ENABLE, W_IN_ENABLE, PSI_IN_ENABLE,
        input  SIZE_N_IN, U_IN, W_IN, PSI_IN,
        output READY, W_HEAD_OUT, U_OUT, U_OUT_ENABLE
    );
endinterface

// File: rtl/accelerator_usage_vector_multihead_multiplier.sv
// Combinational fixed-point multiply: full-width product truncated by FRACTION_SIZE.
module accelerator_fixed_multiplier #(
    parameter int unsigned DATA_SIZE     = 64,
    parameter int unsigned FRACTION_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    output logic [DATA_SIZE-1:0] product_c_o
);
    localparam int unsigned PW = 2 * DATA_SIZE;

    logic [PW-1:0] full;

    assign full        = PW'(a_i) * PW'(b_i);
    assign product_c_o = DATA_SIZE'(full >> FRACTION_SIZE);
endmodule

// File: rtl/accelerator_usage_vector_multihead.sv
// DNC memory-usage update over R write heads: u' = (u + w_c - u*w_c) * psi,
// with w_c = 1 - prod(1 - w_i), one location per capture/combine/scale pass.
module accelerator_usage_vector_multihead
    import accelerator_dnc_pkg::*;
#(
    parameter int unsigned DATA_SIZE     = 64,
    parameter int unsigned CONTROL_SIZE  = 64,
    parameter int unsigned FRACTION_SIZE = 32,
    parameter int unsigned WRITE_HEADS   = 2
) (
    input logic CLK,
    input logic RST,
    accelerator_usage_vector_multihead_if.slave bus
);
    localparam int unsigned HEAD_W = (WRITE_HEADS > 1) ? $clog2(WRITE_HEADS) : 1;
    localparam int unsigned SW     = 2 * DATA_SIZE;
    localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(fixed_one(FRACTION_SIZE));

    dnc_state_e            state_q;
    logic [CONTROL_SIZE-1:0] n_q;
    logic [CONTROL_SIZE-1:0] idx_q;
    logic [DATA_SIZE-1:0]  u_q;
    logic [DATA_SIZE-1:0]  psi_q;
    logic [DATA_SIZE-1:0]  c_q;
    logic [DATA_SIZE-1:0]  t_q;
    logic [DATA_SIZE-1:0]  u_out_q;
    logic                  u_got_q;
    logic                  psi_got_q;
    logic                  w_done_q;
    logic [HEAD_W-1:0]     head_q;
    logic                  ready_q;
    logic                  u_out_en_q;

    logic                  cap_u;
    logic                  cap_psi;
    logic                  cap_w;
    logic                  last_head;
    logic                  last_elem;
    logic                  all_held;
    logic [CONTROL_SIZE-1:0] n_start;
    logic [DATA_SIZE-1:0]  u_sat;
    logic [DATA_SIZE-1:0]  w_sat;
    logic [DATA_SIZE-1:0]  psi_sat;
    logic [DATA_SIZE-1:0]  w_cmp;
    logic [DATA_SIZE-1:0]  c_d;
    logic [DATA_SIZE-1:0]  w_c;
    logic [DATA_SIZE-1:0]  u_wc;
    logic [SW-1:0]         sum;
    logic [DATA_SIZE-1:0]  t_d;
    logic [DATA_SIZE-1:0]  u_out_d;

    // Capture qualifiers: only in CAPTURE and only for operands not yet held.
    assign cap_u   = (state_q == ST_CAPTURE) && bus.U_IN_ENABLE   && !u_got_q;
    assign cap_psi = (state_q == ST_CAPTURE) && bus.PSI_IN_ENABLE && !psi_got_q;
    assign cap_w   = (state_q == ST_CAPTURE) && bus.W_IN_ENABLE   && !w_done_q;

    assign last_head = (head_q == HEAD_W'(WRITE_HEADS - 1));
    assign last_elem = (idx_q == n_q - CONTROL_SIZE'(1));
    assign n_start   = CONTROL_SIZE'(bus.SIZE_N_IN);
    assign all_held  = (u_got_q || cap_u) && (psi_got_q || cap_psi)
                    && (w_done_q || (cap_w && last_head));

    assign u_sat   = DATA_SIZE'(sat_one(MAX_W'(bus.U_IN),   FRACTION_SIZE));
    assign w_sat   = DATA_SIZE'(sat_one(MAX_W'(bus.W_IN),   FRACTION_SIZE));
    assign psi_sat = DATA_SIZE'(sat_one(MAX_W'(bus.PSI_IN), FRACTION_SIZE));
    assign w_cmp   = ONE - w_sat;

    accelerator_fixed_multiplier #(
        .DATA_SIZE    (DATA_SIZE),
        .FRACTION_SIZE(FRACTION_SIZE)
    ) u_mul_head (
        .a_i        (c_q),
        .b_i        (w_cmp),
        .product_c_o(c_d)
    );

    // u*w_c never exceeds min(u, w_c), so the sum cannot underflow.
    assign w_c = ONE - c_q;

    accelerator_fixed_multiplier #(
        .DATA_SIZE    (DATA_SIZE),
        .FRACTION_SIZE(FRACTION_SIZE)
    ) u_mul_combine (
        .a_i        (u_q),
        .b_i        (w_c),
        .product_c_o(u_wc)
    );

    assign sum = SW'(u_q) + SW'(w_c) - SW'(u_wc);
    assign t_d = (sum > SW'(ONE)) ? ONE : DATA_SIZE'(sum);

    accelerator_fixed_multiplier #(
        .DATA_SIZE    (DATA_SIZE),
        .FRACTION_SIZE(FRACTION_SIZE)
    ) u_mul_scale (
        .a_i        (t_q),
        .b_i        (psi_q),
        .product_c_o(u_out_d)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            u_q        <= '0;
            psi_q      <= '0;
            c_q        <= ONE;
            t_q        <= '0;
            u_out_q    <= '0;
            u_got_q    <= 1'b0;
            psi_got_q  <= 1'b0;
            w_done_q   <= 1'b0;
            head_q     <= '0;
            ready_q    <= 1'b0;
            u_out_en_q <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            u_out_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        if (n_start != '0) begin
                            n_q       <= n_start;
                            idx_q     <= '0;
                            u_got_q   <= 1'b0;
                            psi_got_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            head_q    <= '0;
                            c_q       <= ONE;
                            state_q   <= ST_CAPTURE;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (cap_u) begin
                        u_q     <= u_sat;
                        u_got_q <= 1'b1;
                    end
                    if (cap_psi) begin
                        psi_q     <= psi_sat;
                        psi_got_q <= 1'b1;
                    end
                    if (cap_w) begin
                        c_q    <= c_d;
                        head_q <= last_head ? '0 : head_q + HEAD_W'(1);
                        if (last_head) begin
                            w_done_q <= 1'b1;
                        end
                    end
                    if (all_held) begin
                        state_q <= ST_COMBINE;
                    end
                end
                ST_COMBINE: begin
                    t_q     <= t_d;
                    state_q <= ST_SCALE;
                end
                ST_SCALE: begin
                    u_out_q    <= u_out_d;
                    u_out_en_q <= 1'b1;
                    u_got_q    <= 1'b0;
                    psi_got_q  <= 1'b0;
                    w_done_q   <= 1'b0;
                    head_q     <= '0;
                    c_q        <= ONE;
                    if (last_elem) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q   <= idx_q + CONTROL_SIZE'(1);
                        state_q <= ST_CAPTURE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.READY        = ready_q;
    assign bus.U_OUT_ENABLE = u_out_en_q;
    assign bus.U_OUT        = u_out_q;
    assign bus.W_HEAD_OUT   = head_q;
endmodule

// File: doc/accelerator_usage_vector_multihead.md
# accelerator_usage_vector_multihead

Streaming DNC memory-usage update for R write heads, in fixed-point.
- Per memory location j computes u(t;j) = (u(t-1;j) + w_c(j) - u(t-1;j)·w_c(j))·psi(t;j), where w_c(j) = 1 - prod over heads i of (1 - w_i(t-1;j)).
- Processes SIZE_N_IN locations per START, one result per element, then pulses READY.
- Sits in the DNC memory datapath between the write-weighting and free-gate (psi) producers and the allocation-weighting block.

## Interface
Parameters:
- DATA_SIZE, 64, operand/result width (unsigned fixed-point).
- CONTROL_SIZE, 64, width of the element counter.
- FRACTION_SIZE, 32, fractional bits; ONE = 1 << FRACTION_SIZE.
- WRITE_HEADS, 2, number of write heads R (≥1).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  begin a vector; ignored unless IDLE.
- READY  out  1  one-cycle pulse at vector completion.
- U_IN_ENABLE  in  1  U_IN valid strobe.
- W_IN_ENABLE  in  1  W_IN valid strobe for the head given by W_HEAD_OUT.
- PSI_IN_ENABLE  in  1  PSI_IN valid strobe.
- SIZE_N_IN  in  DATA_SIZE  element count N, sampled at START.
- U_IN, W_IN, PSI_IN  in  DATA_SIZE  operands.
- W_HEAD_OUT  out  max(1,$clog2(WRITE_HEADS))  index of the next expected head.
- U_OUT  out  DATA_SIZE  result.
- U_OUT_ENABLE  out  1  one-cycle result-valid pulse.

## Operation
States and transitions:
- IDLE → CAPTURE on START with N>0. N is latched and the element index is cleared.
- IDLE → IDLE with a READY pulse on START with N=0.
- CAPTURE accepts strobes. U and PSI are captured once each. W strobes are taken in head order 0..R-1 via W_HEAD_OUT. The three streams may interleave in any order, including the same cycle.
- A strobe for an operand already captured for the current element is ignored. Strobes outside CAPTURE are ignored.
- CAPTURE → COMBINE once U, PSI and all R heads are held.
- COMBINE → SCALE.
- SCALE → CAPTURE for the next element, or → IDLE when index = N-1.

Arithmetic (all intermediates ≥ 2·DATA_SIZE bits):
- Any operand > ONE is saturated to ONE on capture.
- Products are truncated: (a·b) >> FRACTION_SIZE.
- Running complement c starts at ONE at each element. It updates as c = (c·(ONE - w_i)) >> F as each head is captured.
- COMBINE: w_c = ONE - c; t = u + w_c - ((u·w_c) >> F), clamped to ONE.
- SCALE: U_OUT = (t·psi) >> F.

## Timing
- Reset values: READY=0, U_OUT_ENABLE=0, U_OUT=0, W_HEAD_OUT=0. State is IDLE and all captured flags are cleared.
- Latency: if the last operand is captured at edge k, U_OUT is registered at edge k+2. U_OUT_ENABLE is high for exactly the cycle after edge k+2.
- U_OUT holds its value until the next result.
- READY pulses in the same cycle as the final U_OUT_ENABLE.
- Handshake: upstream must not present element j+1 operands before element j's U_OUT_ENABLE. Operands sent during COMBINE or SCALE are dropped.
- Reset mid-operation: all progress is abandoned and outputs return to reset values. No READY is produced.
- START received while not IDLE is ignored.
- With WRITE_HEADS=1, W_HEAD_OUT is constant 0.

## Structure
- Shared package accelerator_dnc_pkg holds:
  - the state encoding (IDLE, CAPTURE, COMBINE, SCALE);
  - the ONE computation;
  - the saturate-to-ONE function.
- One sub-module: accelerator_fixed_multiplier, a combinational DATA_SIZE×DATA_SIZE multiply with truncating shift by FRACTION_SIZE.
  - Three instances: the head complement, u·w_c, and t·psi.
- FSM, index counter, head counter and capture flags live in the top module.

## Test plan
All scenarios use DATA_SIZE=16, FRACTION_SIZE=8 (ONE=256), WRITE_HEADS=2.
- Single element. Stimulus: N=1, u=128, w0=128, w1=0, psi=256. Response: U_OUT=192 with U_OUT_ENABLE 2 cycles after the last capture, READY in the same cycle.
- Two heads combine. Stimulus: u=0, w0=128, w1=128, psi=128. Response: c=64, w_c=192, U_OUT=96.
- Saturation. Stimulus: u=0, w0=300, w1=0, psi=256. Response: w0 treated as 256, U_OUT=256.
- Empty vector. Stimulus: START with N=0. Response: READY pulse next cycle, no U_OUT_ENABLE.
- Ordering and duplicates. Stimulus: N=3; per element send psi, w0, u, w1 in separate cycles, plus a second U strobe before w1. Response: the extra strobe is ignored, W_HEAD_OUT steps 0→1→0, and three U_OUT_ENABLE pulses occur with READY coincident with the third.
- Reset mid-op. Stimulus: drive RST low during CAPTURE of element 2 of 4. Response: all outputs 0 and no READY. A subsequent START with N=1 completes normally.
